// File: rtl/fp_normaliza_arredonda.sv
// Post-ALU FP stage: normalise, round-to-nearest-even, pack IEEE-754 single.
// Define FP_NORM_LZC_EN for single-cycle LZC/barrel-shift normalisation.
module fp_normaliza_arredonda #(
  parameter int EXP_W   = 8,
  parameter int FRAC_W  = 23,
  parameter int MAX_EXP = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [FRAC_W+3:0]      in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRAC_W:0]  out_result,
  output logic                   out_overflow,
  output logic                   out_underflow
);

  localparam int MW = FRAC_W + 4;
  localparam int XW = EXP_W + 2;
  localparam int RW = EXP_W + FRAC_W + 1;
  localparam logic [XW-1:0] EMAX = XW'(MAX_EXP);
  localparam logic [XW-1:0] ONE  = XW'(1);

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    RENORM,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   mant_q, mant_d;
  logic [XW-1:0]   exp_q, exp_d;
  logic            sign_q, sign_d;
  logic [RW-1:0]   res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            inc;
  logic [MW-3:0]   rnd_sum;
  logic [MW-1:0]   rn_mant;
  logic [XW-1:0]   exp_inc;
  logic [RW-1:0]   zero_res;
  logic [RW-1:0]   inf_res;

  assign inc      = mant_q[1] & (mant_q[0] | mant_q[2]);
  assign rnd_sum  = mant_q[MW-1:2] + {{(MW-3){1'b0}}, inc};
  assign rn_mant  = {1'b0, mant_q[MW-1:1]};
  assign exp_inc  = exp_q + ONE;
  assign zero_res = {sign_q, {(RW-1){1'b0}}};
  assign inf_res  = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

`ifdef FP_NORM_LZC_EN
  logic [XW-1:0] lz_cnt;
  logic [XW-1:0] lz_lim;
  logic [XW-1:0] lz_sh;
  logic [MW-1:0] lz_mant;

  // Shift is clamped so the exponent never drops below 1.
  always_comb begin
    lz_cnt = XW'(MW - 1);
    for (int i = 0; i < MW - 1; i++) begin
      if (mant_q[i]) lz_cnt = XW'(MW - 2 - i);
    end
    lz_lim  = (exp_q > ONE) ? exp_q - ONE : '0;
    lz_sh   = (lz_cnt < lz_lim) ? lz_cnt : lz_lim;
    lz_mant = mant_q << lz_sh;
  end
`endif

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = XW'(in_exp);
          mant_d  = in_mant;
          res_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          res_d   = zero_res;
          state_d = DONE;
        end else if (mant_q[MW-1]) begin
          mant_d  = {1'b0, mant_q[MW-1:2],
                     mant_q[1] | mant_q[0]};
          exp_d   = exp_inc;
          state_d = ROUND;
        end else if (mant_q[MW-2]) begin
          state_d = ROUND;
        end else begin
`ifdef FP_NORM_LZC_EN
          if (!lz_mant[MW-2]) begin
            res_d   = zero_res;
            unf_d   = 1'b1;
            state_d = DONE;
          end else begin
            mant_d  = lz_mant;
            exp_d   = exp_q - lz_sh;
            state_d = ROUND;
          end
`else
          if (exp_q <= ONE) begin
            res_d   = zero_res;
            unf_d   = 1'b1;
            state_d = DONE;
          end else begin
            mant_d = {mant_q[MW-2:0], 1'b0};
            exp_d  = exp_q - ONE;
          end
`endif
        end
      end
      ROUND: begin
        mant_d = {rnd_sum, 2'b00};
        if (rnd_sum[MW-3]) begin
          state_d = RENORM;
        end else if (exp_q >= EMAX) begin
          res_d   = inf_res;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          res_d   = {sign_q, exp_q[EXP_W-1:0],
                     rnd_sum[FRAC_W-1:0]};
          state_d = DONE;
        end
      end
      RENORM: begin
        mant_d  = rn_mant;
        exp_d   = exp_inc;
        state_d = DONE;
        if (exp_inc >= EMAX) begin
          res_d = inf_res;
          ovf_d = 1'b1;
        end else begin
          res_d = {sign_q, exp_inc[EXP_W-1:0],
                   rn_mant[FRAC_W+1:2]};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_normaliza_arredonda.sv
// Directed-vector bench for fp_normaliza_arredonda.
// Latency expectations follow FP_NORM_LZC_EN when defined.
module tb_fp_normaliza_arredonda;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  fp_normaliza_arredonda dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    logic [31:0] r;
    logic        ov;
    logic        un;
    int          ls;
    int          ll;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  int   pass_cnt;
  int   total_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic run(input int i);
    int cnt;
    int lat;
    in_sign  = vecs[i].s;
    in_exp   = vecs[i].e;
    in_mant  = vecs[i].m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
`ifdef FP_NORM_LZC_EN
    lat = vecs[i].ll;
`else
    lat = vecs[i].ls;
`endif
    check($sformatf("v%0d result", i), out_result, vecs[i].r);
    check($sformatf("v%0d ovf", i), 32'(out_overflow), 32'(vecs[i].ov));
    check($sformatf("v%0d unf", i), 32'(out_underflow), 32'(vecs[i].un));
    check($sformatf("v%0d latency", i), 32'(cnt), 32'(lat));
  endtask

  task automatic drain(input int i);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("v%0d valid drop", i), 32'(out_valid), 32'd0);
    check($sformatf("v%0d ready back", i), 32'(in_ready), 32'd1);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    vecs[0]  = '{1'b0, 8'd130,
                 {1'b0, 1'b1, 23'b01000011001100110011010, 2'b00},
                 32'h4121999A, 1'b0, 1'b0, 2, 2};
    vecs[1]  = '{1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 2, 2};
    vecs[2]  = '{1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 2, 2};
    vecs[3]  = '{1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 2, 2};
    vecs[4]  = '{1'b0, 8'd127, 27'h2000003, 32'h3F800001, 1'b0, 1'b0, 2, 2};
    vecs[5]  = '{1'b0, 8'd127, 27'h2000005, 32'h3F800001, 1'b0, 1'b0, 2, 2};
    vecs[6]  = '{1'b0, 8'd127, 27'h4000005, 32'h40000001, 1'b0, 1'b0, 2, 2};
    vecs[7]  = '{1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 3, 3};
    vecs[8]  = '{1'b0, 8'd130, 27'h0100000, 32'h3E800000, 1'b0, 1'b0, 7, 2};
    vecs[9]  = '{1'b1, 8'd254, 27'h4000000, 32'hFF800000, 1'b1, 1'b0, 2, 2};
    vecs[10] = '{1'b0, 8'd2,   27'h0400000, 32'h00000000, 1'b0, 1'b1, 2, 1};
    vecs[11] = '{1'b1, 8'd5,   27'h0000000, 32'h80000000, 1'b0, 1'b0, 1, 1};
    vecs[12] = '{1'b0, 8'd255, 27'h2000000, 32'h7F800000, 1'b1, 1'b0, 2, 2};
    vecs[13] = '{1'b1, 8'd1,   27'h1000000, 32'h80000000, 1'b0, 1'b1, 1, 1};
    vecs[14] = '{1'b0, 8'd10,  27'h1000003, 32'h04800002, 1'b0, 1'b0, 3, 2};
    vecs[15] = '{1'b0, 8'd254, 27'h3FFFFFE, 32'h7F800000, 1'b1, 1'b0, 3, 3};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", out_result, 32'd0);
    check("rst ovf", 32'(out_overflow), 32'd0);
    check("rst unf", 32'(out_underflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run(i);
      drain(i);
    end

    // Back-pressure: result must hold and new inputs be ignored.
    run(0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_sign  = 1'b1;
      in_exp   = 8'd200;
      in_mant  = 27'h4000000;
      @(posedge clk); #1;
      check($sformatf("bp%0d valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d result", k), out_result, 32'h4121999A);
      check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain(0);
    run(1);
    drain(1);

    // Reset while the word is still being normalised.
    in_sign  = vecs[8].s;
    in_exp   = vecs[8].e;
    in_mant  = vecs[8].m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid busy", 32'(in_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst valid", 32'(out_valid), 32'd0);
    check("mid rst result", out_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post rst idle", 32'(in_ready), 32'd1);
    check("post rst valid", 32'(out_valid), 32'd0);

    // Reset while a flagged result is waiting in DONE.
    run(9);
    #1 reset = 1'b1;
    #1;
    check("done rst result", out_result, 32'd0);
    check("done rst ovf", 32'(out_overflow), 32'd0);
    check("done rst valid", 32'(out_valid), 32'd0);
    check("done rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run(0);
    drain(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
